// File: rtl/jtag_pkg.sv
// Shared TAP state encoding and IR capture constants for the JTAG front end.
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_t;

  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller: state register plus TMS-driven next-state logic.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_nxt;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state <= TLR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:      state_nxt = tms ? TLR    : RTI;
      RTI:      state_nxt = tms ? SEL_DR : RTI;
      SEL_DR:   state_nxt = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_nxt = tms ? EX1_DR : SH_DR;
      SH_DR:    state_nxt = tms ? EX1_DR : SH_DR;
      EX1_DR:   state_nxt = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_nxt = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_nxt = tms ? UPD_DR : SH_DR;
      UPD_DR:   state_nxt = tms ? SEL_DR : RTI;
      SEL_IR:   state_nxt = tms ? TLR    : CAP_IR;
      CAP_IR:   state_nxt = tms ? EX1_IR : SH_IR;
      SH_IR:    state_nxt = tms ? EX1_IR : SH_IR;
      EX1_IR:   state_nxt = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_nxt = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_nxt = tms ? UPD_IR : SH_IR;
      UPD_IR:   state_nxt = tms ? SEL_DR : RTI;
      default:  state_nxt = TLR;
    endcase
  end

endmodule

// File: rtl/jtag_ir_ctrl.sv
// JTAG TAP front end: TAP FSM, configurable-length IR, one-hot DR decode and BYPASS.
// Optional JTAG_IR_STATUS_EN adds the ir_status port feeding the upper Capture-IR bits.
module jtag_ir_ctrl
  import jtag_pkg::*;
#(
  parameter int unsigned               IR_LEN     = 4,
  parameter int unsigned               NUM_DR     = 4,
  parameter logic [NUM_DR*IR_LEN-1:0]  DR_OPCODES = {4'h3, 4'h2, 4'h8, 4'h1},
  parameter int unsigned               IDCODE_IDX = 0
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              TMS,
  input  logic              TDI,
  input  logic [NUM_DR-1:0] dr_tdo,
`ifdef JTAG_IR_STATUS_EN
  input  logic [IR_LEN-3:0] ir_status,
`endif
  output logic              TDO,
  output logic              TDO_EN,
  output logic [IR_LEN-1:0] ir_latched,
  output logic [NUM_DR-1:0] dr_sel,
  output logic              bypass_sel,
  output logic              capture_dr,
  output logic              shift_dr,
  output logic              update_dr,
  output logic              tlr
);

  localparam logic [IR_LEN-1:0] IDCODE_OP = DR_OPCODES[IDCODE_IDX*IR_LEN +: IR_LEN];

  tap_state_t        state;
  logic [IR_LEN-1:0] ir_sr;
  logic [IR_LEN-1:0] ir_capture;
  logic              bypass_reg;
  logic              dr_bit;

  jtag_tap_fsm u_fsm (
    .tck   (TCK),
    .trst  (TRST),
    .tms   (TMS),
    .state (state)
  );

  assign capture_dr = (state == CAP_DR);
  assign shift_dr   = (state == SH_DR);
  assign update_dr  = (state == UPD_DR);
  assign tlr        = (state == TLR);

`ifdef JTAG_IR_STATUS_EN
  assign ir_capture = {ir_status, IR_CAPTURE_LSBS};
`else
  assign ir_capture = IR_LEN'(IR_CAPTURE_LSBS);
`endif

  // IR shift register, LSB shifted out first
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr <= '0;
    end else begin
      case (state)
        TLR:     ir_sr <= '0;
        CAP_IR:  ir_sr <= ir_capture;
        SH_IR:   ir_sr <= {TDI, ir_sr[IR_LEN-1:1]};
        default: ir_sr <= ir_sr;
      endcase
    end
  end

  // Instruction takes effect on the falling edge inside Update-IR
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST)               ir_latched <= IDCODE_OP;
    else if (state == TLR)   ir_latched <= IDCODE_OP;
    else if (state == UPD_IR) ir_latched <= ir_sr;
  end

  always_comb begin
    dr_sel = '0;
    for (int unsigned i = 0; i < NUM_DR; i++) begin
      if (ir_latched == DR_OPCODES[i*IR_LEN +: IR_LEN]) dr_sel[i] = 1'b1;
    end
    bypass_sel = ~|dr_sel;
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST)                      bypass_reg <= 1'b0;
    else if (capture_dr && bypass_sel) bypass_reg <= 1'b0;
    else if (shift_dr && bypass_sel)   bypass_reg <= TDI;
  end

  assign dr_bit = bypass_sel ? bypass_reg : |(dr_sel & dr_tdo);

  // TDO launched on the falling edge so the host samples it on the next rising edge
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO_EN <= (state == SH_IR) || (state == SH_DR);
      case (state)
        SH_IR:   TDO <= ir_sr[0];
        SH_DR:   TDO <= dr_bit;
        default: TDO <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_ir_ctrl.sv
// Self-checking bench for jtag_ir_ctrl with default parameters; honours JTAG_IR_STATUS_EN.
module tb_jtag_ir_ctrl;

  logic       TCK;
  logic       TRST;
  logic       TMS;
  logic       TDI;
  logic [3:0] dr_tdo;
`ifdef JTAG_IR_STATUS_EN
  logic [1:0] ir_status;
`endif
  logic       TDO;
  logic       TDO_EN;
  logic [3:0] ir_latched;
  logic [3:0] dr_sel;
  logic       bypass_sel;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       tlr;

  int   errors;
  int   checks;
  logic exp_q[$];
  logic [3:0] cap_pat;

  jtag_ir_ctrl dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .TDI        (TDI),
    .dr_tdo     (dr_tdo),
`ifdef JTAG_IR_STATUS_EN
    .ir_status  (ir_status),
`endif
    .TDO        (TDO),
    .TDO_EN     (TDO_EN),
    .ir_latched (ir_latched),
    .dr_sel     (dr_sel),
    .bypass_sel (bypass_sel),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .tlr        (tlr)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode of the default opcode table: {bypass_sel, dr_sel}
  function automatic logic [4:0] exp_decode(input logic [3:0] ir);
    case (ir)
      4'h1:    return 5'b00001;
      4'h8:    return 5'b00010;
      4'h2:    return 5'b00100;
      4'h3:    return 5'b01000;
      default: return 5'b10000;
    endcase
  endfunction

  // Drive TMS/TDI, clock one posedge, return just after the following negedge
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic test_reset();
    TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; dr_tdo = 4'h0;
    repeat (3) @(negedge TCK);
    #1;
    checks++;
    if (tlr !== 1'b1) begin errors++; $display("FAIL reset_tlr: got %b expected 1", tlr); end
    checks++;
    if (ir_latched !== 4'h1) begin errors++; $display("FAIL reset_ir: got %h expected 1", ir_latched); end
    checks++;
    if ({bypass_sel, dr_sel} !== 5'b00001) begin
      errors++; $display("FAIL reset_sel: got %b expected 00001", {bypass_sel, dr_sel});
    end
    checks++;
    if ({TDO, TDO_EN, capture_dr, shift_dr, update_dr} !== 5'b0) begin
      errors++; $display("FAIL reset_outs: got %b expected 00000", {TDO, TDO_EN, capture_dr, shift_dr, update_dr});
    end
    TRST = 1'b1;
    step(1'b1, 1'b0);
    checks++;
    if (tlr !== 1'b1) begin errors++; $display("FAIL reset_hold_tlr: got %b expected 1", tlr); end
    step(1'b0, 1'b0);
  endtask

  // From RTI: full IR scan of op, checking the captured bits appear on TDO
  task automatic test_ir_shift(input logic [3:0] op);
    logic exp;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(cap_pat[i]);
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (TDO !== exp || TDO_EN !== 1'b1) begin
        errors++; $display("FAIL ir_shift_tdo[%0d]: got tdo=%b en=%b expected tdo=%b en=1", i, TDO, TDO_EN, exp);
      end
      step(i == 3, op[i]);
    end
    step(1'b1, 1'b0);
    checks++;
    if (ir_latched !== op || {bypass_sel, dr_sel} !== exp_decode(op)) begin
      errors++; $display("FAIL ir_update: got ir=%h sel=%b expected ir=%h sel=%b",
                         ir_latched, {bypass_sel, dr_sel}, op, exp_decode(op));
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_dr_select();
    test_ir_shift(4'h8);
    dr_tdo = 4'b0010;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (capture_dr !== 1'b1) begin errors++; $display("FAIL capture_dr: got %b expected 1", capture_dr); end
    step(1'b0, 1'b0);
    checks++;
    if (shift_dr !== 1'b1 || TDO !== 1'b1 || TDO_EN !== 1'b1) begin
      errors++; $display("FAIL dr_mux_hi: got sh=%b tdo=%b en=%b expected 1 1 1", shift_dr, TDO, TDO_EN);
    end
    dr_tdo = 4'b1101;
    step(1'b0, 1'b0);
    checks++;
    if (TDO !== 1'b0) begin errors++; $display("FAIL dr_mux_lo: got %b expected 0", TDO); end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (update_dr !== 1'b1 || TDO_EN !== 1'b0) begin
      errors++; $display("FAIL update_dr: got upd=%b en=%b expected 1 0", update_dr, TDO_EN);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    logic [3:0] din;
    logic       exp;
    din = 4'b1101;
    test_ir_shift(4'hF);
    checks++;
    if (bypass_sel !== 1'b1 || dr_sel !== 4'b0000) begin
      errors++; $display("FAIL bypass_sel: got byp=%b sel=%b expected 1 0000", bypass_sel, dr_sel);
    end
    dr_tdo = 4'hF;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (TDO !== exp) begin errors++; $display("FAIL bypass_tdo[%0d]: got %b expected %b", i, TDO, exp); end
      exp_q.push_back(din[i]);
      step(i == 3, din[i]);
    end
    exp_q.delete();
    checks++;
    if (TDO !== 1'b0 || TDO_EN !== 1'b0) begin
      errors++; $display("FAIL bypass_exit: got tdo=%b en=%b expected 0 0", TDO, TDO_EN);
    end
  endtask

  task automatic test_tlr_from_shift_dr();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (shift_dr !== 1'b1) begin errors++; $display("FAIL reach_shdr: got %b expected 1", shift_dr); end
    repeat (5) step(1'b1, 1'b0);
    checks++;
    if (tlr !== 1'b1 || ir_latched !== 4'h1 || dr_sel !== 4'b0001) begin
      errors++; $display("FAIL tms5_tlr: got tlr=%b ir=%h sel=%b expected 1 1 0001", tlr, ir_latched, dr_sel);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_trst_mid_shift();
    test_ir_shift(4'h8);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    TRST = 1'b0;
    #1;
    checks++;
    if (tlr !== 1'b1 || TDO_EN !== 1'b0 || ir_latched !== 4'h1 || dr_sel !== 4'b0001) begin
      errors++; $display("FAIL trst_abort: got tlr=%b en=%b ir=%h sel=%b expected 1 0 1 0001",
                         tlr, TDO_EN, ir_latched, dr_sel);
    end
    TMS = 1'b1;
    repeat (2) @(negedge TCK);
    #1;
    TRST = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic test_capture_only_update();
    test_ir_shift(4'h8);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (ir_latched !== cap_pat || {bypass_sel, dr_sel} !== exp_decode(cap_pat)) begin
      errors++; $display("FAIL capture_update: got ir=%h sel=%b expected ir=%h sel=%b",
                         ir_latched, {bypass_sel, dr_sel}, cap_pat, exp_decode(cap_pat));
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_ir_shift(4'h2);
    test_ir_shift(4'h3);
    checks++;
    if (dr_sel !== 4'b1000 || bypass_sel !== 1'b0) begin
      errors++; $display("FAIL back_to_back: got sel=%b byp=%b expected 1000 0", dr_sel, bypass_sel);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
`ifdef JTAG_IR_STATUS_EN
    ir_status = 2'b10;
    cap_pat   = 4'b1001;
`else
    cap_pat   = 4'b0001;
`endif
    test_reset();
    test_ir_shift(4'h8);
    test_dr_select();
    test_bypass();
    test_tlr_from_shift_dr();
    test_trst_mid_shift();
    test_capture_only_update();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
